// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives them onto the arithmetic unit, returns results.
// Status flags are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_cmd_sequencer #(
  parameter int N      = 8,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [N-1:0]               cmd_a,
  input  logic [N-1:0]               cmd_b,
  input  logic [2:0]                 cmd_op,
  output logic [N-1:0]               alu_a,
  output logic [N-1:0]               alu_b,
  output logic [2:0]                 alu_s,
  input  logic [N-1:0]               alu_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [N-1:0]               rsp_result,
  output logic [2:0]                 rsp_op,
  output logic                       rsp_zero,
  output logic                       rsp_neg,
  output logic                       rsp_div0,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [SW-1:0]   S_LOAD   = SW'(SETTLE-1);
  localparam logic [2:0]      OP_DIV   = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [N-1:0]    r_mem_a [DEPTH];
  logic [N-1:0]    r_mem_b [DEPTH];
  logic [2:0]      r_mem_op [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;

  logic [N-1:0]    r_alu_a;
  logic [N-1:0]    r_alu_b;
  logic [2:0]      r_alu_s;
  logic [SW-1:0]   r_settle;

  logic            r_rsp_valid;
  logic [N-1:0]    r_rsp_result;
  logic [2:0]      r_rsp_op;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_capture;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid && !w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_settle == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr]  <= cmd_a;
      r_mem_b[r_wptr]  <= cmd_b;
      r_mem_op[r_wptr] <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_s  <= '0;
      r_settle <= '0;
    end else if (w_pop) begin
      r_alu_a  <= r_mem_a[r_rptr];
      r_alu_b  <= r_mem_b[r_rptr];
      r_alu_s  <= r_mem_op[r_rptr];
      r_settle <= S_LOAD;
    end else if (r_state == S_WAIT && r_settle != '0) begin
      r_settle <= r_settle - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
    end else if (w_capture) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= alu_out;
      r_rsp_op     <= r_alu_s;
    end else if (r_state == S_RESP && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_zero;
  logic r_neg;
  logic r_div0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_div0 <= 1'b0;
    end else if (w_capture) begin
      r_zero <= (alu_out == '0);
      r_neg  <= alu_out[N-1];
      r_div0 <= (r_alu_s == OP_DIV) && (r_alu_b == '0);
    end
  end

  assign rsp_zero = r_zero;
  assign rsp_neg  = r_neg;
  assign rsp_div0 = r_div0;
`else
  assign rsp_zero = 1'b0;
  assign rsp_neg  = 1'b0;
  assign rsp_div0 = 1'b0;
`endif

  assign cmd_ready  = !w_full;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_s      = r_alu_s;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_op     = r_rsp_op;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign count      = r_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed table, corner sequences,
// random traffic against a queue-based reference of the ALU and FIFO order.
module tb_alu_cmd_sequencer;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst2_n;
  logic          cmd_valid, cmd_valid2;
  logic          cmd_ready, cmd_ready2;
  logic [N-1:0]  cmd_a, cmd_b;
  logic [2:0]    cmd_op;
  logic [N-1:0]  alu_a, alu_b, alu_a2, alu_b2;
  logic [2:0]    alu_s, alu_s2;
  logic [N-1:0]  alu_out, alu_out2;
  logic          rsp_valid, rsp_valid2;
  logic          rsp_ready;
  logic [N-1:0]  rsp_result, rsp_result2;
  logic [2:0]    rsp_op, rsp_op2;
  logic          rsp_zero, rsp_neg, rsp_div0;
  logic          rsp_zero2, rsp_neg2, rsp_div02;
  logic          busy, busy2;
  logic [CW-1:0] count, count2;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [N-1:0] alu_f(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic [2:0] s);
    case (s)
      3'b001, 3'b100: return a - b;
      3'b010:         return (b == '0) ? '1 : a / b;
      3'b011:         return a * b;
      default:        return a + b;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_a, alu_b, alu_s);
  assign alu_out2 = alu_f(alu_a2, alu_b2, alu_s2);

  alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_div0(rsp_div0),
    .busy(busy), .count(count)
  );

  alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH), .SETTLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst2_n),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2), .alu_out(alu_out2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result2), .rsp_op(rsp_op2),
    .rsp_zero(rsp_zero2), .rsp_neg(rsp_neg2), .rsp_div0(rsp_div02),
    .busy(busy2), .count(count2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] res;
    logic [2:0]   op;
    logic         z;
    logic         n;
    logic         d;
  } rsp_t;

  function automatic rsp_t model(input logic [N-1:0] a,
                                 input logic [N-1:0] b,
                                 input logic [2:0] op);
    rsp_t r;
    r.res = alu_f(a, b, op);
    r.op  = op;
    r.z   = FL && (r.res == '0);
    r.n   = FL && r.res[N-1];
    r.d   = FL && (op == 3'b010) && (b == '0);
    return r;
  endfunction

  // Scoreboard: responses must come back in push order with model values.
  rsp_t exp_q[$];
  initial begin
    rsp_t e;
    logic hold;
    logic [N-1:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("rsp_hold_valid", 32'(rsp_valid), 32'(1));
          chk("rsp_hold_result", 32'(rsp_result), 32'(held));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: got %0h, want none", rsp_result);
          end else begin
            e = exp_q.pop_front();
            chk("sb_result", 32'(rsp_result), 32'(e.res));
            chk("sb_op", 32'(rsp_op), 32'(e.op));
            chk("sb_zero", 32'(rsp_zero), 32'(e.z));
            chk("sb_neg", 32'(rsp_neg), 32'(e.n));
            chk("sb_div0", 32'(rsp_div0), 32'(e.d));
          end
        end
        if (cmd_valid && cmd_ready) begin
          exp_q.push_back(model(cmd_a, cmd_b, cmd_op));
        end
        hold = rsp_valid && !rsp_ready;
        held = rsp_result;
      end
    end
  end

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic [N-1:0] res;
    logic         z;
    logic         n;
    logic         d;
  } vec_t;

  vec_t tbl[10];

  task automatic collect(input int want, output logic [N-1:0] got[$]);
    got.delete();
    for (int k = 0; k < 40 && got.size() < want; k++) begin
      if (rsp_valid) got.push_back(rsp_result);
      step();
    end
    if (got.size() < want) begin
      n_vec++;
      n_err++;
      $display("FAIL collect_timeout: got %0d, want %0d", got.size(), want);
    end
  endtask

  initial begin
    logic [N-1:0] got[$];
    logic [N-1:0] exp_bp[5];
    logic [N-1:0] exp_pp[3];
    int acc;
    bit seen;

    tbl[0] = '{8'd5,   8'd3,   3'b000, 8'h08, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'd3,   8'd5,   3'b001, 8'hFE, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'd7,   8'd7,   3'b100, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'd9,   8'd0,   3'b010, 8'hFF, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{8'd6,   8'd7,   3'b011, 8'h2A, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'd200, 8'd100, 3'b101, 8'h2C, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'd100, 8'd28,  3'b111, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'd250, 8'd5,   3'b010, 8'h32, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{8'd16,  8'd16,  3'b011, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{8'd0,   8'd1,   3'b110, 8'h01, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    rst2_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_valid2 = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b0;
    repeat (3) step();

    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_alu", 32'({alu_a, alu_b, alu_s}), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp", 32'({rsp_result, rsp_op}), 32'(0));
    chk("rst_flags", 32'({rsp_zero, rsp_neg, rsp_div0}), 32'(0));

    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    step();

    // Directed table: one command at a time through an empty pipe.
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("tbl_ready_in", 32'(cmd_ready), 32'(1));
      cmd_a = tbl[i].a;
      cmd_b = tbl[i].b;
      cmd_op = tbl[i].op;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("tbl_c1_count", 32'(count), 32'(1));
      step();
      chk("tbl_c2_alu_a", 32'(alu_a), 32'(tbl[i].a));
      chk("tbl_c2_alu_b", 32'(alu_b), 32'(tbl[i].b));
      chk("tbl_c2_alu_s", 32'(alu_s), 32'(tbl[i].op));
      chk("tbl_c2_novalid", 32'(rsp_valid), 32'(0));
      step();
      chk("tbl_c3_valid", 32'(rsp_valid), 32'(1));
      chk("tbl_c3_result", 32'(rsp_result), 32'(tbl[i].res));
      chk("tbl_c3_op", 32'(rsp_op), 32'(tbl[i].op));
      chk("tbl_c3_zero", 32'(rsp_zero), 32'(tbl[i].z & FL));
      chk("tbl_c3_neg", 32'(rsp_neg), 32'(tbl[i].n & FL));
      chk("tbl_c3_div0", 32'(rsp_div0), 32'(tbl[i].d & FL));
      step();
      chk("tbl_c4_valid", 32'(rsp_valid), 32'(0));
      chk("tbl_c4_busy", 32'(busy), 32'(0));
    end

    // Backpressure until full, then drain in order.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_a = N'(10 + i);
      cmd_b = N'(i);
      cmd_op = 3'b000;
      cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'(5));
    chk("bp_count", 32'(count), 32'(4));
    chk("bp_cmd_ready", 32'(cmd_ready), 32'(0));
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold_result", 32'(rsp_result), 32'(10));
      step();
    end
    rsp_ready = 1'b1;
    exp_bp = '{8'd10, 8'd12, 8'd14, 8'd16, 8'd18};
    collect(5, got);
    for (int i = 0; i < 5; i++) begin
      chk("bp_order", 32'((i < got.size()) ? got[i] : 'x), 32'(exp_bp[i]));
    end
    repeat (2) step();
    chk("bp_count_end", 32'(count), 32'(0));
    chk("bp_busy_end", 32'(busy), 32'(0));

    // Push in the same cycle RESP pops, with two entries queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_a = N'(20 + i);
      cmd_b = 8'd1;
      cmd_op = 3'b001;
      cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !rsp_valid; k++) step();
    chk("pp_valid", 32'(rsp_valid), 32'(1));
    chk("pp_count_before", 32'(count), 32'(2));
    chk("pp_first", 32'(rsp_result), 32'(19));
    cmd_a = 8'd30;
    cmd_b = 8'd2;
    cmd_op = 3'b011;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("pp_count_after", 32'(count), 32'(2));
    exp_pp = '{8'd20, 8'd21, 8'h3C};
    collect(3, got);
    for (int i = 0; i < 3; i++) begin
      chk("pp_order", 32'((i < got.size()) ? got[i] : 'x), 32'(exp_pp[i]));
    end
    repeat (2) step();
    chk("pp_busy_end", 32'(busy), 32'(0));

    // Random traffic, checked by the scoreboard.
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_a = N'($urandom);
      cmd_b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      cmd_op = 3'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 100 && busy; k++) step();
    step();
    chk("rnd_busy_end", 32'(busy), 32'(0));
    chk("rnd_count_end", 32'(count), 32'(0));
    chk("rnd_sb_empty", 32'(exp_q.size()), 32'(0));

    // SETTLE=4 latency on the second instance.
    cmd_a = 8'd12;
    cmd_b = 8'd5;
    cmd_op = 3'b011;
    cmd_valid2 = 1'b1;
    step();
    cmd_valid2 = 1'b0;
    repeat (4) step();
    chk("s4_c5_novalid", 32'(rsp_valid2), 32'(0));
    step();
    chk("s4_c6_valid", 32'(rsp_valid2), 32'(1));
    chk("s4_c6_result", 32'(rsp_result2), 32'h3C);
    step();
    chk("s4_c7_valid", 32'(rsp_valid2), 32'(0));

    // Reset in the second WAIT cycle with two commands queued.
    for (int i = 0; i < 3; i++) begin
      cmd_a = N'(40 + i);
      cmd_b = 8'd3;
      cmd_op = 3'b000;
      cmd_valid2 = 1'b1;
      step();
    end
    cmd_valid2 = 1'b0;
    chk("mr_count_before", 32'(count2), 32'(2));
    rst2_n = 1'b0;
    #1;
    chk("mr_count", 32'(count2), 32'(0));
    chk("mr_cmd_ready", 32'(cmd_ready2), 32'(1));
    chk("mr_busy", 32'(busy2), 32'(0));
    chk("mr_alu", 32'({alu_a2, alu_b2, alu_s2}), 32'(0));
    chk("mr_rsp_valid", 32'(rsp_valid2), 32'(0));
    chk("mr_rsp", 32'({rsp_result2, rsp_op2}), 32'(0));
    chk("mr_flags", 32'({rsp_zero2, rsp_neg2, rsp_div02}), 32'(0));
    repeat (2) step();
    @(negedge clk);
    rst2_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rsp_valid2 || busy2) seen = 1'b1;
    end
    chk("mr_no_rsp_after", 32'(seen), 32'(0));
    chk("mr_count_after", 32'(count2), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
